// File: rtl/fm_tile_loader_pkg.sv
// Shared widths and FSM encoding for the float16 feature-map tile loader.
package fm_tile_loader_pkg;

  localparam int unsigned DATA_WIDTH       = 16;
  localparam int unsigned PARA_X           = 3;
  localparam int unsigned PARA_Y           = 3;
  localparam int unsigned WRITE_ADDR_WIDTH = 3;

  localparam int unsigned TILE_WORDS     = PARA_X * PARA_Y;
  localparam int unsigned TILE_WIDTH     = TILE_WORDS * DATA_WIDTH;
  localparam int unsigned WORD_CNT_WIDTH = $clog2(TILE_WORDS);
  // One extra bit so a full 2^WRITE_ADDR_WIDTH tile count is representable.
  localparam int unsigned TILE_CNT_WIDTH = WRITE_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fm_tile_shift_buffer.sv
// MSB-first word shift register; next_tile_c presents the buffer with din_i
// already shifted in, so the top can capture a full tile on the last accept.
module fm_tile_shift_buffer
  import fm_tile_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [TILE_WIDTH-1:0] next_tile_c
);

  logic [TILE_WIDTH-1:0] buf_q;

  assign next_tile_c = {buf_q[TILE_WIDTH-DATA_WIDTH-1:0], din_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (shift_en_i) begin
      buf_q <= next_tile_c;
    end
  end

endmodule

// File: rtl/fm_tile_loader.sv
// Packs a float16 valid/ready stream into PARA_X*PARA_Y-word tiles and writes
// each tile to the fm RAM with a one-cycle strobe; flags done after the last.
module fm_tile_loader
  import fm_tile_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TILE_CNT_WIDTH-1:0]   tile_count,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [TILE_WIDTH-1:0]       init_fm_data,
  output logic [WRITE_ADDR_WIDTH-1:0] write_fm_data_addr,
  output logic                        fm_write_en,
  output logic                        init_fm_data_done,
  output logic                        busy
);

  state_e                      state_q, state_d;
  logic [WORD_CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [TILE_CNT_WIDTH-1:0]   tile_q, tile_d;
  logic [TILE_CNT_WIDTH-1:0]   count_q, count_d;
  logic [TILE_WIDTH-1:0]       data_q, data_d;
  logic [WRITE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                        in_ready_q, fm_write_en_q, done_q, busy_q;

  logic                        accept;
  logic                        shift_en;
  logic [TILE_WIDTH-1:0]       next_tile_c;

  assign accept = in_valid & in_ready_q;

  fm_tile_shift_buffer u_shift_buffer (
    .clk         (clk),
    .rst         (rst),
    .shift_en_i  (shift_en),
    .din_i       (in_data),
    .next_tile_c (next_tile_c)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tile_d     = tile_q;
    count_d    = count_q;
    data_d     = data_q;
    addr_d     = addr_q;
    shift_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (tile_count != '0) begin
            count_d    = tile_count;
            tile_d     = '0;
            word_cnt_d = '0;
            state_d    = ST_FILL;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL: begin
        if (accept) begin
          shift_en = 1'b1;
          if (word_cnt_q == WORD_CNT_WIDTH'(TILE_WORDS - 1)) begin
            data_d     = next_tile_c;
            addr_d     = tile_q[WRITE_ADDR_WIDTH-1:0];
            word_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            word_cnt_d = word_cnt_q + WORD_CNT_WIDTH'(1);
          end
        end
      end
      ST_WRITE: begin
        if (tile_q + TILE_CNT_WIDTH'(1) == count_q) begin
          state_d = ST_DONE;
        end else begin
          tile_d     = tile_q + TILE_CNT_WIDTH'(1);
          word_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      tile_q        <= '0;
      count_q       <= '0;
      data_q        <= '0;
      addr_q        <= '0;
      in_ready_q    <= 1'b0;
      fm_write_en_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      tile_q        <= tile_d;
      count_q       <= count_d;
      data_q        <= data_d;
      addr_q        <= addr_d;
      in_ready_q    <= (state_d == ST_FILL);
      fm_write_en_q <= (state_d == ST_WRITE);
      done_q        <= (state_d == ST_DONE);
      busy_q        <= (state_d == ST_FILL) || (state_d == ST_WRITE);
    end
  end

  assign in_ready           = in_ready_q;
  assign init_fm_data       = data_q;
  assign write_fm_data_addr = addr_q;
  assign fm_write_en        = fm_write_en_q;
  assign init_fm_data_done  = done_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_fm_tile_loader.sv
// Directed bench for fm_tile_loader: tile vectors with hand-packed expected
// tiles, plus sequences for reset, zero count, ignored start and back-pressure.
module tb_fm_tile_loader;
  import fm_tile_loader_pkg::*;

  typedef struct {
    logic [DATA_WIDTH-1:0] w [TILE_WORDS];
    logic [TILE_WIDTH-1:0] exp_tile;
  } vec_t;

  typedef struct {
    logic [WRITE_ADDR_WIDTH-1:0] addr;
    logic [TILE_WIDTH-1:0]       data;
    logic                        rdy;
  } strobe_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        start = 1'b0;
  logic [TILE_CNT_WIDTH-1:0]   tile_count = '0;
  logic [DATA_WIDTH-1:0]       in_data = '0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [TILE_WIDTH-1:0]       init_fm_data;
  logic [WRITE_ADDR_WIDTH-1:0] write_fm_data_addr;
  logic                        fm_write_en;
  logic                        init_fm_data_done;
  logic                        busy;

  int total = 0;
  int bad   = 0;
  int rd_idx = 0;
  vec_t    vec [7];
  strobe_t cap [$];

  fm_tile_loader dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .tile_count         (tile_count),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .init_fm_data       (init_fm_data),
    .write_fm_data_addr (write_fm_data_addr),
    .fm_write_en        (fm_write_en),
    .init_fm_data_done  (init_fm_data_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Record every write strobe, with the in_ready seen during it.
  always @(negedge clk) begin
    if (!rst && fm_write_en)
      cap.push_back('{addr: write_fm_data_addr, data: init_fm_data, rdy: in_ready});
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int c);
    start = 1'b1;
    tile_count = TILE_CNT_WIDTH'(c);
    step();
    start = 1'b0;
  endtask

  // Presents one word (after gap idle cycles) and waits for it to be accepted.
  task automatic send_word(input logic [DATA_WIDTH-1:0] w, input int gap);
    logic acc;
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data = w;
    n = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: word %0h not accepted in %0d cycles", w, n);
    end
  endtask

  task automatic send_tile(input int v, input int first, input int last, input bit rnd_gap);
    for (int j = first; j <= last; j++)
      send_word(vec[v].w[j], (rnd_gap && j != 0) ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic check_strobe(input string name, input int exp_addr, input int v);
    if (rd_idx < cap.size()) begin
      chk({name, "_addr"}, 160'(cap[rd_idx].addr), 160'(exp_addr));
      chk({name, "_data"}, 160'(cap[rd_idx].data), 160'(vec[v].exp_tile));
      chk({name, "_rdy_low"}, 160'(cap[rd_idx].rdy), 160'(0));
    end else begin
      total++;
      bad++;
      $display("FAIL %s_missing: got %0d strobes want more than %0d", name, cap.size(), rd_idx);
    end
    rd_idx++;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 160'(in_ready), 160'(0));
    chk({name, "_we"},    160'(fm_write_en), 160'(0));
    chk({name, "_addr"},  160'(write_fm_data_addr), 160'(0));
    chk({name, "_data"},  160'(init_fm_data), 160'(0));
    chk({name, "_done"},  160'(init_fm_data_done), 160'(0));
    chk({name, "_busy"},  160'(busy), 160'(0));
  endtask

  initial begin
    vec[0].w = '{16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h3c00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vec[0].exp_tile = 144'h4200_4000_0000_4000_3c00_0000_0000_0000_0000;
    vec[1].w = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    vec[1].exp_tile = 144'h3c00_4000_4200_4400_4500_4600_4700_4800_4880;
    vec[2].w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009};
    vec[2].exp_tile = 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
    vec[3].w = '{16'hbc00, 16'hc000, 16'hc200, 16'hc400, 16'hc500, 16'hc600, 16'hc700, 16'hc800, 16'hc880};
    vec[3].exp_tile = 144'hbc00_c000_c200_c400_c500_c600_c700_c800_c880;
    vec[4].w = '{16'h7bff, 16'h0400, 16'h8000, 16'h7c00, 16'hfc00, 16'h7e00, 16'h3555, 16'h2e66, 16'h1234};
    vec[4].exp_tile = 144'h7bff_0400_8000_7c00_fc00_7e00_3555_2e66_1234;
    vec[5].w = '{16'ha5a5, 16'h5a5a, 16'hffff, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    vec[5].exp_tile = 144'ha5a5_5a5a_ffff_0000_1111_2222_3333_4444_5555;
    vec[6].w = '{16'hdead, 16'hbeef, 16'hcafe, 16'hf00d, 16'h0bad, 16'hc0de, 16'h1357, 16'h2468, 16'h9abc};
    vec[6].exp_tile = 144'hdead_beef_cafe_f00d_0bad_c0de_1357_2468_9abc;

    // Reset state, observed before any clock edge.
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Zero tile count: done next cycle, no strobe.
    pulse_start(0);
    chk("cnt0_done", 160'(init_fm_data_done), 160'(1));
    chk("cnt0_busy", 160'(busy), 160'(0));
    chk("cnt0_we", 160'(fm_write_en), 160'(0));
    repeat (3) step();
    chk("cnt0_no_strobe", 160'(cap.size()), 160'(0));

    // Single tile at full rate: strobe the cycle after the 9th accept.
    pulse_start(1);
    chk("t1_done_cleared", 160'(init_fm_data_done), 160'(0));
    chk("t1_ready", 160'(in_ready), 160'(1));
    send_tile(0, 0, TILE_WORDS - 1, 1'b0);
    in_valid = 1'b0;
    chk("t1_we", 160'(fm_write_en), 160'(1));
    chk("t1_addr", 160'(write_fm_data_addr), 160'(0));
    chk("t1_data", 160'(init_fm_data), 160'(vec[0].exp_tile));
    chk("t1_ready_in_write", 160'(in_ready), 160'(0));
    step();
    chk("t1_done", 160'(init_fm_data_done), 160'(1));
    chk("t1_we_single", 160'(fm_write_en), 160'(0));
    repeat (2) step();
    chk("t1_done_held", 160'(init_fm_data_done), 160'(1));
    check_strobe("t1_cap", 0, 0);

    // Four tiles with random gaps; valid held through every WRITE cycle.
    pulse_start(4);
    for (int t = 0; t < 4; t++) send_tile(1 + t, 0, TILE_WORDS - 1, 1'b1);
    in_valid = 1'b0;
    chk("t4_done_not_yet", 160'(init_fm_data_done), 160'(0));
    step();
    chk("t4_done", 160'(init_fm_data_done), 160'(1));
    repeat (2) step();
    chk("t4_strobes", 160'(cap.size() - rd_idx), 160'(4));
    for (int t = 0; t < 4; t++) check_strobe($sformatf("t4_tile%0d", t), t, 1 + t);

    // Async reset in the middle of the second tile.
    pulse_start(2);
    send_tile(5, 0, TILE_WORDS - 1, 1'b0);
    send_tile(6, 0, 4, 1'b0);
    in_valid = 1'b0;
    check_strobe("rst_tile0", 0, 5);
    rst = 1'b1;
    #2 chk_all_zero("midrst");
    step();
    rst = 1'b0;
    step();
    pulse_start(1);
    send_tile(2, 0, TILE_WORDS - 1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("postrst_done", 160'(init_fm_data_done), 160'(1));
    chk("postrst_strobes", 160'(cap.size() - rd_idx), 160'(1));
    check_strobe("postrst", 0, 2);

    // Start while busy must not change the latched count.
    pulse_start(2);
    send_tile(3, 0, 3, 1'b0);
    in_valid = 1'b0;
    pulse_start(1);
    chk("ign_busy", 160'(busy), 160'(1));
    send_tile(3, 4, TILE_WORDS - 1, 1'b0);
    in_valid = 1'b0;
    step();
    step();
    chk("ign_not_done", 160'(init_fm_data_done), 160'(0));
    chk("ign_still_busy", 160'(busy), 160'(1));
    send_tile(4, 0, TILE_WORDS - 1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("ign_done", 160'(init_fm_data_done), 160'(1));
    step();
    chk("ign_strobes", 160'(cap.size() - rd_idx), 160'(2));
    check_strobe("ign_tile0", 0, 3);
    check_strobe("ign_tile1", 1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
